// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, access-length
// codes and default bus widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    LEN_BYTE = 2'd0,
    LEN_HALF = 2'd1,
    LEN_WORD = 2'd2
  } len_e;

  localparam int unsigned ADDR_L_DEF = 32;
  localparam int unsigned DATA_L_DEF = 32;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first requester at or after ptr
// (round-robin) or the lowest-index requester (fixed priority).
module mem_port_arbiter_rr_pick #(
  parameter int unsigned N_PORT = 4,
  parameter int unsigned IDX_W  = $clog2(N_PORT)
) (
  input  logic [N_PORT-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  input  logic              mode_i,
  output logic [IDX_W-1:0]  gnt_o,
  output logic              valid_o
);

  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] sel;
  logic             found;
  int unsigned      idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    base  = mode_i ? ptr_i : '0;
    for (int unsigned off = 0; off < N_PORT; off++) begin
      idx = (32'(base) + off) % N_PORT;
      sel = IDX_W'(idx);
      if (!found && req_i[sel]) begin
        found = 1'b1;
        gnt_o = sel;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port arbiter merging per-port memory requests onto one external bus, with
// grant locking, registered read return and a watchdog timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned N_PORT  = 4,
  parameter int unsigned ADDR_L  = ADDR_L_DEF,
  parameter int unsigned DATA_L  = DATA_L_DEF,
  parameter int unsigned LEN_L   = 2,
  parameter bit          RR_MODE = 1'b1,
  parameter int unsigned TMO_L   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PORT-1:0]        p_req,
  input  logic [N_PORT-1:0]        p_we,
  input  logic [N_PORT*ADDR_L-1:0] p_addr,
  input  logic [N_PORT*DATA_L-1:0] p_wdata,
  input  logic [N_PORT*LEN_L-1:0]  p_len,
  output logic [N_PORT-1:0]        p_ack,
  output logic                     p_err,
  output logic [DATA_L-1:0]        p_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_L-1:0]        mem_addr,
  output logic [DATA_L-1:0]        mem_wdata,
  output logic [LEN_L-1:0]         mem_len,
  input  logic                     mem_ack,
  input  logic [DATA_L-1:0]        mem_rdata,
  output logic                     busy
);

  localparam int unsigned IDX_W = $clog2(N_PORT);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [TMO_L-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_L-1:0] addr_q, addr_d;
  logic [DATA_L-1:0] wdata_q, wdata_d;
  logic [LEN_L-1:0]  len_q, len_d;
  logic              req_q, req_d;
  logic [N_PORT-1:0] ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_L-1:0] rdata_q, rdata_d;

  logic [IDX_W-1:0]  pick_gnt;
  logic              pick_valid;

  logic [ADDR_L-1:0] addr_a  [N_PORT];
  logic [DATA_L-1:0] wdata_a [N_PORT];
  logic [LEN_L-1:0]  len_a   [N_PORT];

  for (genvar i = 0; i < N_PORT; i++) begin : g_unpack
    assign addr_a[i]  = p_addr[i*ADDR_L +: ADDR_L];
    assign wdata_a[i] = p_wdata[i*DATA_L +: DATA_L];
    assign len_a[i]   = p_len[i*LEN_L +: LEN_L];
  end

  mem_port_arbiter_rr_pick #(
    .N_PORT (N_PORT),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req_i   (p_req),
    .ptr_i   (ptr_q),
    .mode_i  (RR_MODE),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    req_d   = req_q;
    ack_d   = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          we_d    = p_we[pick_gnt];
          addr_d  = addr_a[pick_gnt];
          wdata_d = wdata_a[pick_gnt];
          len_d   = len_a[pick_gnt];
          req_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Ack is tested first so it wins over a simultaneous saturation.
        if (mem_ack) begin
          rdata_d      = mem_rdata;
          err_d        = 1'b0;
          req_d        = 1'b0;
          ack_d[gnt_q] = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == '1) begin
            rdata_d      = '0;
            err_d        = 1'b1;
            req_d        = 1'b0;
            ack_d[gnt_q] = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (RR_MODE) begin
          ptr_d = (gnt_q == IDX_W'(N_PORT - 1)) ? '0 : gnt_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      req_q   <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign p_ack     = ack_q;
  assign p_err     = err_q;
  assign p_rdata   = rdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_len   = len_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance, both
// with a 4-bit watchdog, driven through hand-timed transactions.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;

  logic [3:0]   p_req, p_we, p_ack;
  logic [127:0] p_addr, p_wdata;
  logic [7:0]   p_len;
  logic         p_err;
  logic [31:0]  p_rdata;
  logic         mem_req, mem_we, mem_ack, busy;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [1:0]   mem_len;

  logic [3:0]   f_p_req, f_p_we, f_p_ack;
  logic [127:0] f_p_addr, f_p_wdata;
  logic [7:0]   f_p_len;
  logic         f_p_err;
  logic [31:0]  f_p_rdata;
  logic         f_mem_req, f_mem_we, f_mem_ack, f_busy;
  logic [31:0]  f_mem_addr, f_mem_wdata, f_mem_rdata;
  logic [1:0]   f_mem_len;

  int total = 0;
  int bad   = 0;
  int ackcnt [4];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N_PORT(4), .ADDR_L(32), .DATA_L(32), .LEN_L(2), .RR_MODE(1'b1), .TMO_L(4)
  ) u_rr (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_len(p_len),
    .p_ack(p_ack), .p_err(p_err), .p_rdata(p_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_len(mem_len), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(
    .N_PORT(4), .ADDR_L(32), .DATA_L(32), .LEN_L(2), .RR_MODE(1'b0), .TMO_L(4)
  ) u_fp (
    .clk(clk), .rst(rst),
    .p_req(f_p_req), .p_we(f_p_we), .p_addr(f_p_addr), .p_wdata(f_p_wdata), .p_len(f_p_len),
    .p_ack(f_p_ack), .p_err(f_p_err), .p_rdata(f_p_rdata),
    .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_len(f_mem_len), .mem_ack(f_mem_ack), .mem_rdata(f_mem_rdata), .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction acked in the first WAIT cycle; expects grant g.
  task automatic xact(input bit fp, input int g, input string tag);
    tick;
    chk({tag, "_addr"}, fp ? f_mem_addr : mem_addr, 64'(32'h100 * (g + 1)));
    tick;
    if (fp) f_mem_ack = 1'b1; else mem_ack = 1'b1;
    tick;
    chk({tag, "_ack"}, fp ? f_p_ack : p_ack, 64'(4'b0001 << g));
    if (!fp) for (int i = 0; i < 4; i++) ackcnt[i] += int'(p_ack[i]);
    mem_ack   = 1'b0;
    f_mem_ack = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0;
    p_req = '0; p_we = '0; p_wdata = '0; p_len = '0; mem_ack = 1'b0; mem_rdata = '0;
    f_p_req = '0; f_p_we = '0; f_p_wdata = '0; f_p_len = '0; f_mem_ack = 1'b0; f_mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      p_addr[i*32 +: 32]   = 32'h100 * (i + 1);
      f_p_addr[i*32 +: 32] = 32'h100 * (i + 1);
      ackcnt[i] = 0;
    end
    tick;
    tick;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p_ack", p_ack, 0);
    chk("rst_p_err", p_err, 0);
    chk("rst_p_rdata", p_rdata, 0);
    chk("rst_f_mem_req", f_mem_req, 0);
    rst = 1'b1;

    // Single read, ack three cycles after mem_req rises.
    p_req = 4'b0001;
    tick;
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_busy", busy, 1);
    tick; tick; tick;
    chk("rd_wait_req", mem_req, 1);
    chk("rd_wait_ack", p_ack, 0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick;
    chk("rd_p_ack", p_ack, 4'b0001);
    chk("rd_p_rdata", p_rdata, 32'hDEADBEEF);
    chk("rd_p_err", p_err, 0);
    chk("rd_req_drop", mem_req, 0);
    mem_ack = 1'b0; mem_rdata = 32'h5555AAAA; p_req = '0;
    tick;
    chk("rd_ack_pulse", p_ack, 0);
    chk("rd_idle", busy, 0);

    rst = 1'b0;
    tick;
    rst = 1'b1;

    // Round-robin fairness with all ports requesting.
    p_req = 4'b1111;
    for (int k = 0; k < 4; k++) xact(1'b0, k, $sformatf("rr%0d", k));
    for (int i = 0; i < 4; i++) chk($sformatf("rr_cnt%0d", i), ackcnt[i], 1);
    xact(1'b0, 0, "rr_wrap");

    // Timeout on port 1; an ack during ISSUE must be ignored.
    p_req = 4'b0010;
    tick;
    chk("tmo_addr", mem_addr, 32'h200);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    repeat (14) tick;
    chk("tmo_hold_req", mem_req, 1);
    chk("tmo_hold_ack", p_ack, 0);
    tick;
    chk("tmo_req_drop", mem_req, 0);
    chk("tmo_p_ack", p_ack, 4'b0010);
    chk("tmo_p_err", p_err, 1);
    chk("tmo_p_rdata", p_rdata, 0);
    p_req = '0;
    tick;
    chk("tmo_idle", busy, 0);

    // Write where the ack coincides with counter saturation.
    p_req = 4'b0100; p_we = 4'b0100;
    p_wdata[2*32 +: 32] = 32'h12345678; p_len[2*2 +: 2] = 2'd2;
    mem_rdata = 32'hCAFEF00D;
    tick;
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_len", mem_len, 2);
    p_wdata[2*32 +: 32] = 32'hFFFFFFFF; p_we = 4'b0000;
    tick;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("wr_wdata_w%0d", i), mem_wdata, 32'h12345678);
      if (i == 14) mem_ack = 1'b1;
      tick;
    end
    chk("wr_p_ack", p_ack, 4'b0100);
    chk("wr_p_err", p_err, 0);
    chk("wr_p_rdata", p_rdata, 32'hCAFEF00D);
    mem_ack = 1'b0; p_req = '0;
    tick;

    // Reset mid-WAIT: port 3 granted from ptr=3, then port 0 after reset.
    p_req = 4'b1001;
    tick;
    chk("mr_addr", mem_addr, 32'h400);
    tick; tick;
    rst = 1'b0;
    #1;
    chk("mr_req_low", mem_req, 0);
    chk("mr_busy_low", busy, 0);
    tick;
    chk("mr_no_ack", p_ack, 0);
    rst = 1'b1;
    tick;
    chk("mr_regrant", mem_addr, 32'h100);
    tick;
    mem_ack = 1'b1;
    tick;
    chk("mr_p_ack", p_ack, 4'b0001);
    mem_ack = 1'b0; p_req = '0;
    tick;

    // Fixed priority: port 1 wins until it stops requesting.
    f_p_req = 4'b1010;
    xact(1'b1, 1, "fp0");
    xact(1'b1, 1, "fp1");
    xact(1'b1, 1, "fp2");
    f_p_req[1] = 1'b0;
    xact(1'b1, 3, "fp3");
    f_p_req = '0;
    tick;
    chk("fp_idle", f_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter that merges the core's read/write memory ports (instruction-fetch cache, data cache, future ports) onto one external memory bus.
- Generalises the fixed R_PORT/W_PORT wiring to N_PORT channels with selectable fixed-priority or round-robin arbitration.
- Adds request locking, registered read return, and a watchdog timeout with an error response.
- Sits between the per-port caches and the top-level memory interface.

Parameters:
- N_PORT, 4, number of requester channels (2..8)
- ADDR_L, 32, address width
- DATA_L, 32, data width
- LEN_L, 2, access-length code width (byte/half/word)
- RR_MODE, 1, 1 = round-robin; 0 = fixed priority, port 0 highest
- TMO_L, 8, timeout counter width; timeout fires after 2^TMO_L-1 wait cycles

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- p_req  in  N_PORT  per-port request, held high until the matching p_ack
- p_we  in  N_PORT  per-port write enable (0 = read)
- p_addr  in  N_PORT*ADDR_L  packed addresses, port i at [i*ADDR_L +: ADDR_L]
- p_wdata  in  N_PORT*DATA_L  packed write data
- p_len  in  N_PORT*LEN_L  packed length codes
- p_ack  out  N_PORT  one-cycle completion pulse to the granted port
- p_err  out  1  valid with p_ack; 1 = transaction timed out
- p_rdata  out  DATA_L  read data, valid with p_ack for reads
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  ADDR_L  bus address
- mem_wdata  out  DATA_L  bus write data
- mem_len  out  LEN_L  bus length
- mem_ack  in  1  bus completion pulse; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_L  bus read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; rr pointer=0; timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any p_req is high, select the grant index g. In RR_MODE, g is the first requester at or after ptr, searching modulo N_PORT. Otherwise g is the lowest-index requester.
  - Latch g and port g's we/addr/wdata/len into bus registers, then go to ISSUE.
- ISSUE: mem_req=1 with the latched fields; counter cleared; go to WAIT next cycle.
- WAIT:
  - mem_req stays 1 and the bus fields stay stable.
  - On mem_ack: capture mem_rdata into p_rdata, set err=0, drop mem_req, go to RESP.
  - Otherwise increment the counter. When it reaches all-ones, drop mem_req, set err=1 and p_rdata=0, go to RESP.
- RESP:
  - p_ack[g]=1 and p_err=err for exactly one cycle.
  - If RR_MODE, ptr=(g+1) mod N_PORT.
  - Go to IDLE.
- Latency: request seen in IDLE at cycle t → mem_req at t+1. mem_ack at cycle u → p_ack at u+1.
- Minimum occupancy per transaction is 4 cycles (IDLE, ISSUE, WAIT, RESP). There is no back-to-back bypass.
- Locking: the grant is held until RESP. Changes on other ports, or on the granted port's inputs after the latch, are ignored.
- A requester must keep p_req high until p_ack. The requester deasserts p_req in the cycle after p_ack, so IDLE sees it low; the RESP→IDLE ordering guarantees no double grant.
- mem_ack outside WAIT is ignored.
- mem_ack in the same cycle the counter reaches all-ones: the ack wins and err=0.
- Round-robin pointer wraps from N_PORT-1 to 0. A pointer pointing at a non-requester is skipped.
- Reset asserted mid-transaction: immediate return to IDLE and mem_req=0. No p_ack is issued for the aborted transaction.
- No output is combinationally dependent on any input; all outputs are registered.

Decomposition:
- Shared def package: state encodings (IDLE/ISSUE/WAIT/RESP), length codes (byte/half/word), ADDR/DATA width defaults.
- One sub-module: rr_pick, a purely combinational N_PORT-wide rotating priority encoder. Inputs are req vector, ptr and mode; outputs are grant index and valid.
- The FSM, counter and bus registers stay in the top module.

Test Plan:
- Single read: p_req=0001, addr 0x100, mem_ack 3 cycles after mem_req with rdata 0xDEADBEEF → mem_addr=0x100, mem_we=0, p_ack=0001 one cycle later, p_rdata=0xDEADBEEF, p_err=0.
- Round-robin fairness: RR_MODE=1, p_req=1111 held, mem_ack in the cycle after ISSUE for every transaction → grant order 0,1,2,3,0; each port gets exactly one p_ack per 4 transactions.
- Fixed priority: RR_MODE=0, p_req=1010 held → port 1 granted repeatedly; port 3 granted only after p_req[1] drops.
- Timeout: TMO_L=4, mem_ack never asserted → mem_req drops after 15 WAIT cycles; p_ack to the granted port with p_err=1 and p_rdata=0.
- Write then ack/timeout collision: write wdata 0x12345678, len=word; mem_ack on the cycle the counter saturates → p_err=0, mem_wdata=0x12345678 stable for the whole WAIT.
- Reset mid-WAIT: rst low for 1 cycle during WAIT → mem_req=0 and busy=0 immediately; no p_ack; after release the held p_req is re-granted with ptr=0.
